// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator SRAM read/write controllers.
package accum_pkg;

  // Read-controller FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } accum_rd_state_e;

  // Row-address width for a bank of the given depth.
  function automatic int unsigned accum_addr_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Row-count width: one extra bit so a full-bank length (== rows) is representable.
  function automatic int unsigned accum_len_w(input int unsigned rows);
    return accum_addr_w(rows) + 1;
  endfunction

endpackage

// File: rtl/accum_skew_line.sv
// Generic shift register with every stage exposed; tap k is the input delayed k+1 cycles.
module accum_skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic [WIDTH-1:0]            i_d,
  output logic [DEPTH-1:0][WIDTH-1:0] o_taps
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  // Shift one stage per cycle; synchronous clear flushes every stage.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_taps = r_stage;

endmodule

// File: rtl/accum_rd_ctrl.sv
// Accumulator SRAM read-side controller: drains len rows from a base address,
// skewing enable/address by one cycle per systolic column and tracking read latency.
// Requires SYS_COL >= 2 and RD_LAT >= 1.
module accum_rd_ctrl
  import accum_pkg::*;
#(
  parameter int unsigned  SYS_COL    = 16,
  parameter int unsigned  ACCUM_ROW  = 256,
  parameter int unsigned  RD_LAT     = 1,
  localparam int unsigned ADDR_WIDTH = accum_addr_w(ACCUM_ROW)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [ADDR_WIDTH-1:0]              req_addr,
  input  logic [ADDR_WIDTH:0]                req_len,
  output logic [SYS_COL-1:0]                 rd_en_out,
  output logic [SYS_COL-1:0][ADDR_WIDTH-1:0] rd_addr_out,
  output logic [SYS_COL-1:0]                 rd_data_valid,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(SYS_COL + RD_LAT);
  // DRAIN edges to wait before raising done so it lands with the last column's valid.
  localparam logic [CNT_W-1:0]      DRAIN_LOAD = CNT_W'(SYS_COL + RD_LAT - 3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(ACCUM_ROW - 1);
  localparam logic [LEN_W-1:0]      LEN_ONE    = LEN_W'(1);

  accum_rd_state_e             r_state;
  logic                        r_en0;
  logic [ADDR_WIDTH-1:0]       r_addr0;
  logic [LEN_W-1:0]            r_rows_left;
  logic [CNT_W-1:0]            r_drain_cnt;
  logic                        r_done;

  logic                        w_accept;
  logic [ADDR_WIDTH-1:0]       w_addr_next;
  logic [SYS_COL-2:0][ADDR_WIDTH:0] w_skew_taps;
  logic [RD_LAT-1:0][SYS_COL-1:0]   w_lat_taps;

  assign req_ready   = (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign done        = r_done;
  assign w_accept    = req_valid && req_ready;
  // Row address wraps modulo the bank depth, which need not be a power of two.
  assign w_addr_next = (r_addr0 == ADDR_LAST) ? '0 : r_addr0 + ADDR_WIDTH'(1);

  // FSM, row counter and column-0 address counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_en0       <= 1'b0;
      r_addr0     <= '0;
      r_rows_left <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_addr0     <= req_addr;
            r_rows_left <= req_len;
            r_drain_cnt <= DRAIN_LOAD;
            if (req_len == '0) begin
              // Nothing to read: complete on the very next cycle.
              r_state <= StDrain;
              r_done  <= 1'b1;
            end else begin
              r_state <= StIssue;
              r_en0   <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (r_rows_left == LEN_ONE) begin
            r_en0   <= 1'b0;
            r_state <= StDrain;
          end else begin
            r_rows_left <= r_rows_left - LEN_ONE;
            r_addr0     <= w_addr_next;
          end
        end
        StDrain: begin
          if (r_done) begin
            r_state <= StIdle;
          end else if (r_drain_cnt == '0) begin
            r_done <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Column skew: column j sees column 0's enable/address j cycles later.
  accum_skew_line #(
    .DEPTH(SYS_COL - 1),
    .WIDTH(ADDR_WIDTH + 1)
  ) u_col_skew (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_d   ({r_en0, r_addr0}),
    .o_taps(w_skew_taps)
  );

  assign rd_en_out[0]   = r_en0;
  assign rd_addr_out[0] = r_addr0;

  for (genvar j = 1; j < SYS_COL; j++) begin : g_col
    assign rd_en_out[j]   = w_skew_taps[j-1][ADDR_WIDTH];
    assign rd_addr_out[j] = w_skew_taps[j-1][ADDR_WIDTH-1:0];
  end

  // SRAM latency: data valid is each column's enable delayed RD_LAT cycles.
  accum_skew_line #(
    .DEPTH(RD_LAT),
    .WIDTH(SYS_COL)
  ) u_lat (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_d   (rd_en_out),
    .o_taps(w_lat_taps)
  );

  assign rd_data_valid = w_lat_taps[RD_LAT-1];

endmodule

// File: tb/tb_accum_rd_ctrl.sv
// Directed self-checking bench for accum_rd_ctrl (RD_LAT=1 instance plus an RD_LAT=3 instance).
module tb_accum_rd_ctrl;

  localparam int unsigned SYS_COL   = 16;
  localparam int unsigned ACCUM_ROW = 256;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned RD_LAT_B  = 3;
  localparam int unsigned AW        = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                       req_valid, req_ready, busy, done;
  logic [AW-1:0]              req_addr;
  logic [AW:0]                req_len;
  logic [SYS_COL-1:0]         rd_en_out, rd_data_valid;
  logic [SYS_COL-1:0][AW-1:0] rd_addr_out;

  logic                       req_valid_b, req_ready_b, busy_b, done_b;
  logic [AW-1:0]              req_addr_b;
  logic [AW:0]                req_len_b;
  logic [SYS_COL-1:0]         rd_en_out_b, rd_data_valid_b;
  logic [SYS_COL-1:0][AW-1:0] rd_addr_out_b;

  int n_chk = 0;
  int n_err = 0;
  int cnt1 [SYS_COL];
  int cnt2 [SYS_COL];
  logic [SYS_COL-1:0] seen_en, seen_vld;
  logic seen_done;

  accum_rd_ctrl #(
    .SYS_COL  (SYS_COL),
    .ACCUM_ROW(ACCUM_ROW),
    .RD_LAT   (RD_LAT)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .rd_en_out    (rd_en_out),
    .rd_addr_out  (rd_addr_out),
    .rd_data_valid(rd_data_valid),
    .busy         (busy),
    .done         (done)
  );

  accum_rd_ctrl #(
    .SYS_COL  (SYS_COL),
    .ACCUM_ROW(ACCUM_ROW),
    .RD_LAT   (RD_LAT_B)
  ) u_dut_b (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid_b),
    .req_ready    (req_ready_b),
    .req_addr     (req_addr_b),
    .req_len      (req_len_b),
    .rd_en_out    (rd_en_out_b),
    .rd_addr_out  (rd_addr_out_b),
    .rd_data_valid(rd_data_valid_b),
    .busy         (busy_b),
    .done         (done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the RD_LAT=1 instance and check every output each cycle
  // against the timing formulas until req_ready returns. Starts and ends mid-cycle, idle.
  task automatic run_req(input int addr, input int len, input string name);
    int d;
    logic [SYS_COL-1:0] e_en, e_vld;
    d = (len == 0) ? 1 : len + SYS_COL - 1 + RD_LAT;
    chk({name, "_ready_pre"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_len   = (AW+1)'(len);
    @(negedge clk);
    // Accepted fields must be latched; scramble the inputs afterwards.
    req_valid = 1'b0;
    req_addr  = ~req_addr;
    req_len   = (AW+1)'(len + 7);
    for (int k = 1; k <= d + 1; k++) begin
      for (int j = 0; j < SYS_COL; j++) begin
        e_en[j]  = (k >= 1 + j) && (k <= len + j);
        e_vld[j] = (k >= 1 + j + RD_LAT) && (k <= len + j + RD_LAT);
      end
      chk($sformatf("%s_en_c%0d", name, k), 64'(rd_en_out), 64'(e_en));
      chk($sformatf("%s_vld_c%0d", name, k), 64'(rd_data_valid), 64'(e_vld));
      chk($sformatf("%s_done_c%0d", name, k), 64'(done), 64'(k == d));
      chk($sformatf("%s_busy_c%0d", name, k), 64'(busy), 64'(k <= d));
      chk($sformatf("%s_ready_c%0d", name, k), 64'(req_ready), 64'(k > d));
      for (int j = 0; j < SYS_COL; j++) begin
        if (e_en[j]) begin
          chk($sformatf("%s_addr_col%0d_c%0d", name, j, k), 64'(rd_addr_out[j]),
              64'((addr + k - 1 - j) % ACCUM_ROW));
        end
      end
      if (k < d + 1) @(negedge clk);
    end
  endtask

  initial begin
    req_valid   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    req_valid_b = 1'b0;
    req_addr_b  = '0;
    req_len_b   = '0;

    // Reset state.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", 64'(rd_en_out), 64'd0);
    chk("rst_addr", 64'(rd_addr_out[SYS_COL-1]), 64'd0);
    chk("rst_vld", 64'(rd_data_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);

    // Basic, wrap, zero length, full bank with wrap.
    run_req(10, 4, "base");
    run_req(254, 4, "wrap");
    run_req(0, 0, "len0");
    run_req(5, ACCUM_ROW, "full");

    // Back-to-back: len 3 then len 5 with req_valid held high.
    for (int j = 0; j < SYS_COL; j++) begin
      cnt1[j] = 0;
      cnt2[j] = 0;
    end
    req_valid = 1'b1;
    req_addr  = 8'd20;
    req_len   = 9'd3;
    @(negedge clk);
    req_addr = 8'd40;
    req_len  = 9'd5;
    for (int k = 1; k <= 41; k++) begin
      for (int j = 0; j < SYS_COL; j++) begin
        if (rd_en_out[j]) begin
          if (k <= 20) cnt1[j]++;
          else cnt2[j]++;
        end
      end
      if (k == 1) chk("b2b_addr1", 64'(rd_addr_out[0]), 64'd20);
      if (k == 19) begin
        chk("b2b_done1", 64'(done), 64'd1);
        chk("b2b_ready19", 64'(req_ready), 64'd0);
      end
      if (k == 20) chk("b2b_ready20", 64'(req_ready), 64'd1);
      if (k == 21) begin
        chk("b2b_busy21", 64'(busy), 64'd1);
        chk("b2b_addr2", 64'(rd_addr_out[0]), 64'd40);
        req_valid = 1'b0;
      end
      if (k == 40) chk("b2b_done40", 64'(done), 64'd0);
      if (k == 41) chk("b2b_done2", 64'(done), 64'd1);
      if (k < 41) @(negedge clk);
    end
    for (int j = 0; j < SYS_COL; j++) begin
      chk($sformatf("b2b_cnt1_col%0d", j), 64'(cnt1[j]), 64'd3);
      chk($sformatf("b2b_cnt2_col%0d", j), 64'(cnt2[j]), 64'd5);
    end
    @(negedge clk);
    chk("b2b_ready_end", 64'(req_ready), 64'd1);

    // Reset in the middle of a len=32 request.
    req_valid = 1'b1;
    req_addr  = 8'd0;
    req_len   = 9'd32;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mrst_en", 64'(rd_en_out), 64'd0);
    chk("mrst_addr0", 64'(rd_addr_out[0]), 64'd0);
    chk("mrst_addr5", 64'(rd_addr_out[5]), 64'd0);
    chk("mrst_vld", 64'(rd_data_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_ready", 64'(req_ready), 64'd1);
    rstn = 1'b1;
    seen_en   = '0;
    seen_vld  = '0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen_en   = seen_en | rd_en_out;
      seen_vld  = seen_vld | rd_data_valid;
      seen_done = seen_done | done;
    end
    chk("mrst_no_en", 64'(seen_en), 64'd0);
    chk("mrst_no_vld", 64'(seen_vld), 64'd0);
    chk("mrst_no_done", 64'(seen_done), 64'd0);
    run_req(100, 2, "post_rst");

    // RD_LAT=3 instance, len=1.
    chk("lat3_ready_pre", 64'(req_ready_b), 64'd1);
    req_valid_b = 1'b1;
    req_addr_b  = 8'd7;
    req_len_b   = 9'd1;
    @(negedge clk);
    req_valid_b = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic [SYS_COL-1:0] e_en, e_vld;
      for (int j = 0; j < SYS_COL; j++) begin
        e_en[j]  = (k == 1 + j);
        e_vld[j] = (k == 1 + j + 3);
      end
      chk($sformatf("lat3_en_c%0d", k), 64'(rd_en_out_b), 64'(e_en));
      chk($sformatf("lat3_vld_c%0d", k), 64'(rd_data_valid_b), 64'(e_vld));
      chk($sformatf("lat3_done_c%0d", k), 64'(done_b), 64'(k == 19));
      if (k <= SYS_COL) begin
        chk($sformatf("lat3_addr_c%0d", k), 64'(rd_addr_out_b[k-1]), 64'd7);
      end
      if (k < 20) @(negedge clk);
    end
    chk("lat3_ready_end", 64'(req_ready_b), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
